obi_rr_mux: RTL and testbench

Round-robin OBI multiplexer that shares one OBI subordinate (master-side port) between `NumSlvPorts` requesting managers. It arbitrates address phases, holds the winner stable until granted, and records the winner's index in an in-order ID FIFO. R-channel responses are returned to the correct requester. It is the counterpart to `obi_demux` and sits wherever several cores or DMAs share one memory or peripheral bus.

---
 rtl/obi_rr_mux.sv | 178 +++++++++++++++++
 tb/tb_obi_rr_mux.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_rr_mux.sv
// Round-robin OBI multiplexer: N managers share one subordinate.
// In-order ID FIFO steers responses back to the issuing manager.
package obi_pkg;
   typedef struct packed {
      bit          UseRReady;
      bit          Integrity;
      int unsigned AddrWidth;
      int unsigned DataWidth;
   } obi_cfg_t;

   localparam obi_cfg_t ObiDefaultConfig = '{
      UseRReady: 1'b0,
      Integrity: 1'b0,
      AddrWidth: 32,
      DataWidth: 32
   };

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_a_chan_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } obi_r_chan_t;

   typedef struct packed {
      logic        req;
      obi_a_chan_t a;
      logic        rready;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      obi_r_chan_t r;
      logic        rvalid;
   } obi_rsp_t;
endpackage

module obi_rr_mux #(
   parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
   parameter type obi_req_t = obi_pkg::obi_req_t,
   parameter type obi_rsp_t = obi_pkg::obi_rsp_t,
   parameter int unsigned NumSlvPorts = 2,
   parameter int unsigned NumMaxTrans = 2,
   parameter type idx_t = logic [$clog2(NumSlvPorts)-1:0]
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  obi_req_t slv_ports_req_i [NumSlvPorts],
   output obi_rsp_t slv_ports_rsp_o [NumSlvPorts],
   output obi_req_t mst_port_req_o,
   input  obi_rsp_t mst_port_rsp_i
);

   localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
   localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [CntW-1:0] cnt_t;

   if (NumSlvPorts < 2) begin : g_err_ports
      $fatal(1, "obi_rr_mux: NumSlvPorts must be at least 2");
   end
   if (NumMaxTrans < 1) begin : g_err_trans
      $fatal(1, "obi_rr_mux: NumMaxTrans must be at least 1");
   end
   if (ObiCfg.Integrity) begin : g_err_integrity
      $fatal(1, "obi_rr_mux: Integrity is not implemented");
   end

   idx_t rr_q, rr_d;
   logic lock_q, lock_d;
   idx_t lock_idx_q, lock_idx_d;
   idx_t mem_q [NumMaxTrans];
   ptr_t wptr_q, wptr_d;
   ptr_t rptr_q, rptr_d;
   cnt_t cnt_q, cnt_d;

   idx_t arb_sel, cand, sel, head;
   logic arb_found;
   logic fifo_full, fifo_empty, blocked;
   logic mst_req, mst_rready, hs, pop;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(NumMaxTrans - 1)) ? '0 : p + 1'b1;
   endfunction

   // First requester after the last winner, wrapping around.
   always_comb begin
      arb_sel   = rr_q;
      arb_found = 1'b0;
      cand      = '0;
      for (int unsigned k = 1; k <= NumSlvPorts; k++) begin
         cand = idx_t'((32'(rr_q) + k) % NumSlvPorts);
         if (!arb_found && slv_ports_req_i[cand].req) begin
            arb_sel   = cand;
            arb_found = 1'b1;
         end
      end
   end

   assign sel        = lock_q ? lock_idx_q : arb_sel;
   assign fifo_full  = (cnt_q == cnt_t'(NumMaxTrans));
   assign fifo_empty = (cnt_q == '0);
   assign blocked    = fifo_full | rst_i;
   assign head       = mem_q[rptr_q];

   assign mst_req    = !blocked & slv_ports_req_i[sel].req;
   assign hs         = mst_req & mst_port_rsp_i.gnt;
   assign mst_rready = ObiCfg.UseRReady ? slv_ports_req_i[head].rready : 1'b1;
   assign pop        = mst_port_rsp_i.rvalid & mst_rready & !fifo_empty;

   always_comb begin
      mst_port_req_o        = slv_ports_req_i[sel];
      mst_port_req_o.req    = mst_req;
      mst_port_req_o.rready = mst_rready;
      for (int unsigned i = 0; i < NumSlvPorts; i++) begin
         slv_ports_rsp_o[i]        = mst_port_rsp_i;
         slv_ports_rsp_o[i].gnt    = hs & (idx_t'(i) == sel);
         slv_ports_rsp_o[i].rvalid = mst_port_rsp_i.rvalid & !fifo_empty
                                   & !rst_i & (idx_t'(i) == head);
      end
   end

   always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      cnt_d      = cnt_q;
      if (hs) begin
         lock_d = 1'b0;
         rr_d   = sel;
         wptr_d = ptr_inc(wptr_q);
      end else if (mst_req) begin
         lock_d     = 1'b1;
         lock_idx_d = sel;
      end
      if (pop) begin
         rptr_d = ptr_inc(rptr_q);
      end
      if (hs && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!hs && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q       <= idx_t'(NumSlvPorts - 1);
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         for (int unsigned i = 0; i < NumMaxTrans; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         if (hs) begin
            mem_q[wptr_q] <= sel;
         end
      end
   end

endmodule

// File: tb/tb_obi_rr_mux.sv
// Bench for obi_rr_mux: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_obi_rr_mux;
   import obi_pkg::*;

   localparam int N = 4;
   localparam int D = 2;
   localparam obi_cfg_t Cfg = '{
      UseRReady: 1'b1,
      Integrity: 1'b0,
      AddrWidth: 32,
      DataWidth: 32
   };

   logic     clk = 1'b0;
   logic     rst;
   obi_req_t sreq [N];
   obi_rsp_t srsp [N];
   obi_req_t mreq;
   obi_rsp_t mrsp;

   always #5 clk = ~clk;

   obi_rr_mux #(
      .ObiCfg      (Cfg),
      .NumSlvPorts (N),
      .NumMaxTrans (D)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .slv_ports_req_i (sreq),
      .slv_ports_rsp_o (srsp),
      .mst_port_req_o  (mreq),
      .mst_port_rsp_i  (mrsp)
   );

   typedef struct {
      logic [3:0] req;
      logic       gnt;
      logic       rv;
      logic [3:0] exp_gnt;
      logic [3:0] exp_rv;
      logic       exp_mreq;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: last winner, lock, and outstanding-ID queue.
   int   m_rr = N - 1;
   bit   m_lock = 1'b0;
   int   m_lidx = 0;
   int   q[$];
   int   e_sel;
   bit   e_mreq;
   logic [3:0] e_gnt, e_rv, d_gnt, d_rv;

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic [3:0] r, input logic g, input logic rv);
      for (int i = 0; i < N; i++) sreq[i].req = r[i];
      mrsp.gnt      = g;
      mrsp.rvalid   = rv;
      mrsp.r.rdata  = $urandom;
      mrsp.r.err    = 1'($urandom_range(0, 1));
   endtask

   task automatic eval();
      int p;
      #2;
      if (m_lock) begin
         e_sel = m_lidx;
      end else begin
         e_sel = -1;
         for (int k = 1; k <= N; k++) begin
            p = (m_rr + k) % N;
            if (e_sel < 0 && sreq[p].req) e_sel = p;
         end
      end
      e_mreq = !rst && (q.size() < D) && (e_sel >= 0) && sreq[e_sel].req;
      e_gnt = '0;
      if (e_mreq && mrsp.gnt) e_gnt[e_sel] = 1'b1;
      e_rv = '0;
      if (!rst && mrsp.rvalid && q.size() > 0) e_rv[q[0]] = 1'b1;
      for (int i = 0; i < N; i++) begin
         d_gnt[i] = srsp[i].gnt;
         d_rv[i]  = srsp[i].rvalid;
      end
      check("mst_req", 128'(mreq.req), 128'(e_mreq));
      if (e_mreq) check("mst_a", 128'(mreq.a), 128'(sreq[e_sel].a));
      check("gnt_vec", 128'(d_gnt), 128'(e_gnt));
      check("rvalid_vec", 128'(d_rv), 128'(e_rv));
      if (q.size() > 0)
         check("mst_rready", 128'(mreq.rready), 128'(sreq[q[0]].rready));
      for (int i = 0; i < N; i++)
         check("r_bcast", 128'(srsp[i].r), 128'(mrsp.r));
   endtask

   task automatic tick();
      if (rst) begin
         q.delete();
         m_rr   = N - 1;
         m_lock = 1'b0;
      end else begin
         if (mrsp.rvalid && q.size() > 0 && sreq[q[0]].rready)
            void'(q.pop_front());
         if (e_mreq && mrsp.gnt) begin
            q.push_back(e_sel);
            m_rr   = e_sel;
            m_lock = 1'b0;
         end else if (e_mreq) begin
            m_lock = 1'b1;
            m_lidx = e_sel;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic [3:0] r, input logic g, input logic rv);
      set_in(r, g, rv);
      eval();
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(4'h0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic dir_addr();
      for (int i = 0; i < N; i++) begin
         sreq[i].a.addr  = 32'h1000 * (i + 1);
         sreq[i].a.we    = 1'b0;
         sreq[i].a.be    = 4'hF;
         sreq[i].a.wdata = i;
         sreq[i].rready  = 1'b1;
      end
   endtask

   vec_t tbl [9];

   initial begin
      tbl = '{
         '{4'hF, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1},
         '{4'hF, 1'b1, 1'b1, 4'b0010, 4'b0001, 1'b1},
         '{4'hF, 1'b1, 1'b1, 4'b0100, 4'b0010, 1'b1},
         '{4'hF, 1'b1, 1'b1, 4'b1000, 4'b0100, 1'b1},
         '{4'hF, 1'b1, 1'b1, 4'b0001, 4'b1000, 1'b1},
         '{4'hF, 1'b1, 1'b1, 4'b0010, 4'b0001, 1'b1},
         '{4'h0, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0},
         '{4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1},
         '{4'h0, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0}
      };
      rst = 1'b1;
      dir_addr();
      set_in(4'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      do_reset();

      // Fairness and single-port table
      foreach (tbl[v]) begin
         set_in(tbl[v].req, tbl[v].gnt, tbl[v].rv);
         eval();
         check("tbl_gnt", 128'(d_gnt), 128'(tbl[v].exp_gnt));
         check("tbl_rv", 128'(d_rv), 128'(tbl[v].exp_rv));
         check("tbl_mreq", 128'(mreq.req), 128'(tbl[v].exp_mreq));
         tick();
      end

      // Lock: address held while gnt is low
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_in(4'b1010, 1'b0, 1'b0);
         eval();
         check("lock_req", 128'(mreq.req), 128'(1'b1));
         check("lock_a", 128'(mreq.a), 128'(sreq[1].a));
         tick();
      end
      set_in(4'b1010, 1'b1, 1'b0);
      eval();
      check("lock_g1", 128'(d_gnt), 128'(4'b0010));
      tick();
      set_in(4'b1010, 1'b1, 1'b0);
      eval();
      check("lock_g3", 128'(d_gnt), 128'(4'b1000));
      tick();
      cyc(4'h0, 1'b0, 1'b1);
      cyc(4'h0, 1'b0, 1'b1);

      // Full stall
      do_reset();
      set_in(4'b0011, 1'b1, 1'b0);
      eval();
      check("full_g0", 128'(d_gnt), 128'(4'b0001));
      tick();
      set_in(4'b0011, 1'b1, 1'b0);
      eval();
      check("full_g1", 128'(d_gnt), 128'(4'b0010));
      tick();
      set_in(4'b0011, 1'b1, 1'b0);
      eval();
      check("full_block", 128'(mreq.req), 128'(1'b0));
      tick();
      set_in(4'b0011, 1'b1, 1'b1);
      eval();
      check("full_rv0", 128'(d_rv), 128'(4'b0001));
      check("full_popgnt", 128'(d_gnt), 128'(4'b0000));
      tick();
      set_in(4'b0011, 1'b1, 1'b0);
      eval();
      check("full_after", 128'(d_gnt), 128'(4'b0001));
      tick();
      cyc(4'h0, 1'b0, 1'b1);
      cyc(4'h0, 1'b0, 1'b1);

      // Ordering with rready backpressure
      do_reset();
      set_in(4'b1000, 1'b1, 1'b0);
      eval();
      check("ord_g3a", 128'(d_gnt), 128'(4'b1000));
      tick();
      set_in(4'b0001, 1'b1, 1'b0);
      eval();
      check("ord_g0", 128'(d_gnt), 128'(4'b0001));
      tick();
      set_in(4'b1000, 1'b1, 1'b1);
      eval();
      check("ord_rv3a", 128'(d_rv), 128'(4'b1000));
      check("ord_fullg", 128'(d_gnt), 128'(4'b0000));
      tick();
      set_in(4'b1000, 1'b1, 1'b0);
      eval();
      check("ord_g3b", 128'(d_gnt), 128'(4'b1000));
      tick();
      sreq[0].rready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         set_in(4'h0, 1'b0, 1'b1);
         eval();
         check("ord_hold_rv", 128'(d_rv), 128'(4'b0001));
         check("ord_hold_rr", 128'(mreq.rready), 128'(1'b0));
         tick();
      end
      sreq[0].rready = 1'b1;
      set_in(4'h0, 1'b0, 1'b1);
      eval();
      check("ord_rv0", 128'(d_rv), 128'(4'b0001));
      tick();
      set_in(4'h0, 1'b0, 1'b1);
      eval();
      check("ord_rv3b", 128'(d_rv), 128'(4'b1000));
      tick();

      // Reset with two outstanding
      do_reset();
      cyc(4'b0011, 1'b1, 1'b0);
      cyc(4'b0011, 1'b1, 1'b0);
      rst = 1'b1;
      set_in(4'b0011, 1'b1, 1'b1);
      eval();
      check("rst_mreq", 128'(mreq.req), 128'(1'b0));
      check("rst_gnt", 128'(d_gnt), 128'(4'b0000));
      check("rst_rv", 128'(d_rv), 128'(4'b0000));
      tick();
      rst = 1'b0;
      set_in(4'h0, 1'b0, 1'b1);
      eval();
      check("stale_rv", 128'(d_rv), 128'(4'b0000));
      tick();
      set_in(4'hF, 1'b1, 1'b0);
      eval();
      check("rst_next_g0", 128'(d_gnt), 128'(4'b0001));
      tick();
      cyc(4'h0, 1'b0, 1'b1);

      // Randomized run against the model
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < N; i++) begin
            sreq[i].a.addr  = $urandom;
            sreq[i].a.we    = 1'($urandom_range(0, 1));
            sreq[i].a.be    = 4'($urandom_range(0, 15));
            sreq[i].a.wdata = $urandom;
            sreq[i].rready  = ($urandom_range(0, 3) != 0);
         end
         set_in(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                (q.size() > 0) && ($urandom_range(0, 1) == 1));
         eval();
         tick();
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
